i2c_xfer_scheduler: RTL
=======================

# i2c_xfer_scheduler

Shares the I2C master controller's AXI-Lite register port between two independent requesters. Each request (read or write, 7-bit target, 1-4 bytes) is arbitrated round-robin, then executed as a fixed AXI-Lite register sequence: program, start, poll status, fetch read data. The block sits between on-chip clients and the M0 AXI-Lite slave port of the I2C master, replacing software-driven register polling.

## Interface
- POLL_GAP, 16: idle cycles between consecutive status polls.
- MAX_POLLS, 500: status reads before a transfer is declared timed out.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  request pending, bit i = requester i; held until accepted.
- req_ready  out  2  one-cycle accept pulse to the granted requester.
- req_rnw  in  2  1 = I2C read, 0 = I2C write.
- req_saddr  in  14  7-bit target address per requester, [6:0] = req 0.
- req_len  in  6  3-bit byte count per requester, [2:0] = req 0; legal 1..4.
- req_wdata  in  64  32-bit write payload per requester, [31:0] = req 0; byte 0 in [7:0].
- rsp_valid  out  2  one-cycle completion pulse to the owning requester.
- rsp_err  out  1  error flag, valid with rsp_valid.
- rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes and errors.
- m_axi_awaddr  out  5, m_axi_awvalid  out  1, m_axi_awready  in  1: write address channel.
- m_axi_wdata  out  32, m_axi_wstrb  out  4 (always 4'hF), m_axi_wvalid  out  1, m_axi_wready  in  1: write data channel.
- m_axi_bresp  in  2, m_axi_bvalid  in  1, m_axi_bready  out  1: write response channel.
- m_axi_araddr  out  5, m_axi_arvalid  out  1, m_axi_arready  in  1: read address channel.
- m_axi_rdata  in  32, m_axi_rresp  in  2, m_axi_rvalid  in  1, m_axi_rready  out  1: read data channel.

## Operation
- Target register map: 0x00 byte count, 0x04 target address, 0x08 RX data, 0x0C TX data, 0x10 control/status. Control write 0x1 = start write, 0x4 = start read. Status bit1 = write done, bit3 = read done.
- States: IDLE, ARB, WR_SADDR, WR_LEN, WR_TX, WR_CTRL, POLL_RD, POLL_WAIT, RD_DATA, RESP.
- IDLE -> ARB when any req_valid is high. ARB grants round-robin: the requester not granted last wins when both are valid; after reset, requester 0 wins. Pulses req_ready, latches rnw/saddr/len/wdata.
- Illegal len (0 or >4): ARB -> RESP with rsp_err=1, no AXI traffic.
- Write request: WR_SADDR (0x04 <- saddr) -> WR_LEN (0x00 <- len) -> WR_TX (0x0C <- wdata) -> WR_CTRL (0x10 <- 0x1).
- Read request: WR_SADDR -> WR_LEN -> WR_CTRL (0x10 <- 0x4); WR_TX skipped.
- POLL_RD reads 0x10. Done bit (bit1 write, bit3 read) set: write -> RESP, read -> RD_DATA. Clear: POLL_WAIT for POLL_GAP cycles, then POLL_RD. After MAX_POLLS clear reads: RESP with rsp_err=1.
- RD_DATA reads 0x08 into rsp_rdata. RESP pulses rsp_valid to the owner, then -> IDLE.
- Any bresp or rresp != 2'b00 aborts to RESP with rsp_err=1.
- Only one transfer in flight. The non-granted request is held off until RESP completes.

## Timing
- Reset values: all outputs 0, including req_ready, rsp_*, every m_axi valid/ready, and the addresses/data. The round-robin pointer is reset to favour requester 0.
- AXI write step: awvalid and wvalid rise together on the cycle after state entry. Each drops on its own handshake cycle. bready is high from issue until bvalid. The step ends on the bvalid cycle.
- AXI read step: arvalid is held until arready. rready is high from issue until rvalid. rdata is captured on the rvalid cycle.
- All outputs are registered.
- With a zero-wait slave, each AXI step takes 3 cycles. Minimum latency from req_valid to rsp_valid is then 3 + 3 per AXI step (one status poll) + 1.
- Request accept: req_ready is high for exactly one cycle. The requester must drop req_valid, or present a new request, on the next cycle.
- Simultaneous request and completion: a request arriving in the RESP cycle is arbitrated in the next ARB.
- Asynchronous reset mid-transfer: the AXI channels drop immediately and no response is issued. The I2C master's own transfer is not cancelled.

## Test plan
- Req0 write, saddr 0x42, len 2, wdata 0xCAFE; status bit1 set on 3rd poll -> AXI writes 0x04=0x42, 0x00=2, 0x0C=0xCAFE, 0x10=0x1; 3 reads of 0x10; rsp_valid[0], rsp_err=0.
- Req1 read, saddr 0x42, len 4; status bit3 set; 0x08 returns 0xDEADBEEF -> no 0x0C write, control write 0x4, rsp_valid[1], rsp_rdata=0xDEADBEEF.
- Both req_valid high continuously after reset -> grants alternate 0,1,0,1; each rsp_valid goes to the matching requester.
- len 0 and len 5 -> rsp_err=1 one cycle after the accept pulse; no AXI valid ever asserted.
- Status never sets, MAX_POLLS=4 -> exactly 4 reads of 0x10 spaced POLL_GAP apart, then rsp_err=1; bresp=2'b10 on the WR_LEN step -> immediate rsp_err=1, no further writes.
- rst_n low during POLL_WAIT -> all outputs 0 asynchronously; after release, a new req0 is served normally.

Source files
------------

// File: rtl/i2c_xfer_scheduler.sv
// Two-requester round-robin front end for the I2C master's AXI-Lite register port.
// Each accepted request becomes a fixed program/start/poll/fetch register sequence.
module i2c_xfer_scheduler #(
  parameter int unsigned PollGap  = 16,
  parameter int unsigned MaxPolls = 500
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [1:0]  req_rnw_i,
  input  logic [13:0] req_saddr_i,
  input  logic [5:0]  req_len_i,
  input  logic [63:0] req_wdata_i,
  output logic [1:0]  rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_rdata_o,
  output logic [4:0]  m_axi_awaddr_o,
  output logic        m_axi_awvalid_o,
  input  logic        m_axi_awready_i,
  output logic [31:0] m_axi_wdata_o,
  output logic [3:0]  m_axi_wstrb_o,
  output logic        m_axi_wvalid_o,
  input  logic        m_axi_wready_i,
  input  logic [1:0]  m_axi_bresp_i,
  input  logic        m_axi_bvalid_i,
  output logic        m_axi_bready_o,
  output logic [4:0]  m_axi_araddr_o,
  output logic        m_axi_arvalid_o,
  input  logic        m_axi_arready_i,
  input  logic [31:0] m_axi_rdata_i,
  input  logic [1:0]  m_axi_rresp_i,
  input  logic        m_axi_rvalid_i,
  output logic        m_axi_rready_o
);

  typedef enum logic [3:0] {
    StIdle, StArb, StWrSaddr, StWrLen, StWrTx, StWrCtrl, StPollRd, StPollWait, StRdData, StResp
  } state_e;

  localparam logic [4:0] RegLen   = 5'h00;
  localparam logic [4:0] RegSaddr = 5'h04;
  localparam logic [4:0] RegRx    = 5'h08;
  localparam logic [4:0] RegTx    = 5'h0C;
  localparam logic [4:0] RegCtrl  = 5'h10;

  state_e      state_q;
  logic        last_q, owner_q, rnw_q, err_q, issued_q;
  logic [6:0]  saddr_q;
  logic [2:0]  len_q;
  logic [31:0] wdata_q, rdata_q;
  logic [15:0] poll_cnt_q, gap_cnt_q;
  logic [1:0]  req_ready_q, rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [4:0]  awaddr_q, araddr_q;
  logic [31:0] axi_wdata_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  logic        gnt;
  logic [6:0]  gnt_saddr;
  logic [2:0]  gnt_len;
  logic [4:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  state_e      wr_next;
  logic        done_bit;

  // On contention the requester that was not served last wins.
  always_comb begin
    gnt = 1'b0;
    if (req_valid_i == 2'b11) gnt = ~last_q;
    else if (req_valid_i[1])  gnt = 1'b1;
    gnt_saddr = gnt ? req_saddr_i[13:7] : req_saddr_i[6:0];
    gnt_len   = gnt ? req_len_i[5:3] : req_len_i[2:0];
  end

  always_comb begin
    wr_addr = RegSaddr;
    wr_data = {25'b0, saddr_q};
    wr_next = StWrLen;
    case (state_q)
      StWrLen: begin
        wr_addr = RegLen;
        wr_data = {29'b0, len_q};
        wr_next = rnw_q ? StWrCtrl : StWrTx;
      end
      StWrTx: begin
        wr_addr = RegTx;
        wr_data = wdata_q;
        wr_next = StWrCtrl;
      end
      StWrCtrl: begin
        wr_addr = RegCtrl;
        wr_data = rnw_q ? 32'h4 : 32'h1;
        wr_next = StPollRd;
      end
      default: ;
    endcase
    rd_addr  = (state_q == StRdData) ? RegRx : RegCtrl;
    done_bit = rnw_q ? m_axi_rdata_i[3] : m_axi_rdata_i[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      rnw_q       <= 1'b0;
      err_q       <= 1'b0;
      issued_q    <= 1'b0;
      saddr_q     <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      poll_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      axi_wdata_q <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        StIdle: if (|req_valid_i) state_q <= StArb;
        StArb: begin
          if (|req_valid_i) begin
            req_ready_q <= gnt ? 2'b10 : 2'b01;
            owner_q     <= gnt;
            last_q      <= gnt;
            rnw_q       <= gnt ? req_rnw_i[1] : req_rnw_i[0];
            saddr_q     <= gnt_saddr;
            len_q       <= gnt_len;
            wdata_q     <= gnt ? req_wdata_i[63:32] : req_wdata_i[31:0];
            rdata_q     <= '0;
            poll_cnt_q  <= '0;
            issued_q    <= 1'b0;
            if (gnt_len == 3'd0 || gnt_len > 3'd4) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              err_q   <= 1'b0;
              state_q <= StWrSaddr;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StWrSaddr, StWrLen, StWrTx, StWrCtrl: begin
          if (!issued_q) begin
            awaddr_q    <= wr_addr;
            axi_wdata_q <= wr_data;
            awvalid_q   <= 1'b1;
            wvalid_q    <= 1'b1;
            bready_q    <= 1'b1;
            issued_q    <= 1'b1;
          end else begin
            if (awvalid_q && m_axi_awready_i) awvalid_q <= 1'b0;
            if (wvalid_q && m_axi_wready_i)   wvalid_q  <= 1'b0;
            if (bready_q && m_axi_bvalid_i) begin
              bready_q <= 1'b0;
              issued_q <= 1'b0;
              if (m_axi_bresp_i != 2'b00) begin
                err_q   <= 1'b1;
                state_q <= StResp;
              end else begin
                state_q <= wr_next;
              end
            end
          end
        end
        StPollRd, StRdData: begin
          if (!issued_q) begin
            araddr_q  <= rd_addr;
            arvalid_q <= 1'b1;
            rready_q  <= 1'b1;
            issued_q  <= 1'b1;
          end else begin
            if (arvalid_q && m_axi_arready_i) arvalid_q <= 1'b0;
            if (rready_q && m_axi_rvalid_i) begin
              rready_q <= 1'b0;
              issued_q <= 1'b0;
              if (m_axi_rresp_i != 2'b00) begin
                err_q   <= 1'b1;
                state_q <= StResp;
              end else if (state_q == StRdData) begin
                rdata_q <= m_axi_rdata_i;
                state_q <= StResp;
              end else if (done_bit) begin
                state_q <= rnw_q ? StRdData : StResp;
              end else if (poll_cnt_q + 16'd1 >= 16'(MaxPolls)) begin
                err_q   <= 1'b1;
                state_q <= StResp;
              end else begin
                poll_cnt_q <= poll_cnt_q + 16'd1;
                gap_cnt_q  <= '0;
                state_q    <= StPollWait;
              end
            end
          end
        end
        StPollWait: begin
          if (gap_cnt_q + 16'd1 >= 16'(PollGap)) state_q <= StPollRd;
          else gap_cnt_q <= gap_cnt_q + 16'd1;
        end
        StResp: begin
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= err_q ? 32'h0 : rdata_q;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o     = req_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_err_o       = rsp_err_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign m_axi_awaddr_o  = awaddr_q;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_wdata_o   = axi_wdata_q;
  assign m_axi_wstrb_o   = 4'hF;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_bready_o  = bready_q;
  assign m_axi_araddr_o  = araddr_q;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_rready_o  = rready_q;

endmodule
